// File: rtl/add16_acc_if.sv
// Handshake bundle between the 16-bit adder stage, the block accumulator and the next stage.
// The slave modport is the accumulator's view; master is the surrounding datapath.
interface add16_acc_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum;
  logic              in_cout;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_ovf;

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/add16_block_accumulator.sv
// Sums BLOCK_LEN adder results ({cout,sum}) into an ACC_W-bit total with a sticky overflow flag.
// Define ACC_SAT_EN to saturate the total at all-ones on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for the first beat of a block, acc/cnt cleared
// ACCUM | collecting beats 2..BLOCK_LEN
// DONE  | total presented on out_*, waiting for out_ready
module add16_block_accumulator #(
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 24,
  parameter int BLOCK_LEN = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  add16_acc_if.slave   bus,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef logic [ACC_W-1:0] acc_t;

  state_t     state, state_nxt;
  acc_t       acc, acc_nxt;
  logic [7:0] cnt, cnt_nxt, cnt_inc;
  logic       ovf, ovf_nxt;
  acc_t       out_acc_q, out_acc_nxt;
  logic       out_ovf_q, out_ovf_nxt;

  acc_t       operand;
  logic [ACC_W:0] sum_ext;
  logic       carry;
  logic       accept;

  assign operand  = acc_t'({bus.in_cout, bus.in_sum});
  assign sum_ext  = {1'b0, acc} + {1'b0, operand};
  assign carry    = sum_ext[ACC_W];
  assign cnt_inc  = cnt + 8'd1;

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_acc   = out_acc_q;
  assign bus.out_ovf   = out_ovf_q;
  assign busy          = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_acc_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      ovf       <= ovf_nxt;
      out_acc_q <= out_acc_nxt;
      out_ovf_q <= out_ovf_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf;
    out_acc_nxt = out_acc_q;
    out_ovf_nxt = out_ovf_q;

    if (clear) begin
      // flush wins over any beat or output handshake in the same cycle
      state_nxt   = IDLE;
      acc_nxt     = '0;
      cnt_nxt     = '0;
      ovf_nxt     = 1'b0;
      out_acc_nxt = '0;
      out_ovf_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_nxt = operand;
            cnt_nxt = 8'd1;
            ovf_nxt = 1'b0;
            if (BLOCK_LEN == 1) begin
              state_nxt   = DONE;
              out_acc_nxt = operand;
              out_ovf_nxt = 1'b0;
            end else begin
              state_nxt = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            ovf_nxt = ovf | carry;
`ifdef ACC_SAT_EN
            acc_nxt = (ovf | carry) ? '1 : sum_ext[ACC_W-1:0];
`else
            acc_nxt = sum_ext[ACC_W-1:0];
`endif
            cnt_nxt = cnt_inc;
            if (cnt_inc == 8'(BLOCK_LEN)) begin
              state_nxt   = DONE;
              out_acc_nxt = acc_nxt;
              out_ovf_nxt = ovf_nxt;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add16_block_accumulator.sv
// Self-checking bench: directed block table, hand-written corner sequences and a randomized
// run against a queue-based reference model; covers the ACC_W=18 and BLOCK_LEN=1 builds too.
module tb_add16_block_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear_a = 1'b0, clear_b = 1'b0, clear_c = 1'b0;
  logic busy_a, busy_b, busy_c;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  add16_acc_if #(.DATA_W(16), .ACC_W(24)) ifa ();
  add16_acc_if #(.DATA_W(16), .ACC_W(18)) ifb ();
  add16_acc_if #(.DATA_W(16), .ACC_W(24)) ifc ();

  add16_block_accumulator #(.DATA_W(16), .ACC_W(24), .BLOCK_LEN(4)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .bus(ifa.slave), .busy(busy_a));
  add16_block_accumulator #(.DATA_W(16), .ACC_W(18), .BLOCK_LEN(4)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .bus(ifb.slave), .busy(busy_b));
  add16_block_accumulator #(.DATA_W(16), .ACC_W(24), .BLOCK_LEN(1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear_c), .bus(ifc.slave), .busy(busy_c));

  typedef struct {
    logic [3:0][15:0] sum;
    logic [3:0]       cout;
    int               gap;
    logic [23:0]      exp_acc;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // inputs change and outputs are sampled 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] s, input logic c);
    int n = 0;
    ifa.in_valid = 1'b1;
    ifa.in_sum   = s;
    ifa.in_cout  = c;
    while (!ifa.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("beat_ready_timeout", 32'd0, 32'd1);
    step();
    ifa.in_valid = 1'b0;
  endtask

  task automatic handoff_a();
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
    chk("handoff_busy", {31'd0, busy_a}, 32'd0);
    chk("handoff_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("handoff_in_ready", {31'd0, ifa.in_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    for (int b = 0; b < 4; b++) begin
      send_beat(v.sum[b], v.cout[b]);
      if (b < 3) repeat (v.gap) step();
    end
    chk("vec_out_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("vec_in_ready", {31'd0, ifa.in_ready}, 32'd0);
    chk("vec_out_acc", {8'd0, ifa.out_acc}, {8'd0, v.exp_acc});
    chk("vec_out_ovf", {31'd0, ifa.out_ovf}, {31'd0, v.exp_ovf});
    handoff_a();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_b;
    int unsigned q[$];
    logic pending;
    logic [23:0] m_acc;
    logic m_ovf;
    longint unsigned tot;

    vecs[0].sum = {16'h0004, 16'h0003, 16'h0002, 16'h0001}; vecs[0].cout = 4'b0000;
    vecs[0].gap = 0; vecs[0].exp_acc = 24'h00000A; vecs[0].exp_ovf = 1'b0;
    vecs[1].sum = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}; vecs[1].cout = 4'b1111;
    vecs[1].gap = 2; vecs[1].exp_acc = 24'h07FFFC; vecs[1].exp_ovf = 1'b0;
    vecs[2].sum = {16'h0000, 16'h0000, 16'h0000, 16'h0000}; vecs[2].cout = 4'b0000;
    vecs[2].gap = 1; vecs[2].exp_acc = 24'h000000; vecs[2].exp_ovf = 1'b0;
    vecs[3].sum = {16'h1234, 16'h0000, 16'h8000, 16'h8000}; vecs[3].cout = 4'b0100;
    vecs[3].gap = 0; vecs[3].exp_acc = 24'h021234; vecs[3].exp_ovf = 1'b0;

    ifa.in_valid = 0; ifa.in_sum = '0; ifa.in_cout = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.in_sum = '0; ifb.in_cout = 0; ifb.out_ready = 0;
    ifc.in_valid = 0; ifc.in_sum = '0; ifc.in_cout = 0; ifc.out_ready = 0;

    // reset state
    #23;
    chk("rst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("rst_out_acc", {8'd0, ifa.out_acc}, 32'd0);
    chk("rst_out_ovf", {31'd0, ifa.out_ovf}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, ifa.in_ready}, 32'd1);

    // directed block table
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // total held while downstream stalls; in_valid stays high and must not be taken
    send_beat(16'h4, 1'b0); send_beat(16'h4, 1'b0); send_beat(16'h4, 1'b0); send_beat(16'h4, 1'b0);
    ifa.in_valid = 1'b1; ifa.in_sum = 16'h0007; ifa.in_cout = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", {31'd0, ifa.out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, ifa.in_ready}, 32'd0);
      chk("stall_out_acc", {8'd0, ifa.out_acc}, 32'h10);
      step();
    end
    ifa.out_ready = 1'b1;
    step();
    ifa.out_ready = 1'b0;
    ifa.in_valid = 1'b0;
    chk("stall_handoff_busy", {31'd0, busy_a}, 32'd0);
    chk("stall_hold_acc", {8'd0, ifa.out_acc}, 32'h10);
    run_vec(vecs[0]);

    // clear after two beats drops the partial sum and a simultaneous beat
    send_beat(16'h9, 1'b0); send_beat(16'h9, 1'b0);
    clear_a = 1'b1; ifa.in_valid = 1'b1; ifa.in_sum = 16'h0100; ifa.in_cout = 1'b0;
    chk("clear_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    step();
    clear_a = 1'b0; ifa.in_valid = 1'b0;
    chk("clear_busy", {31'd0, busy_a}, 32'd0);
    chk("clear_out_acc", {8'd0, ifa.out_acc}, 32'd0);
    send_beat(16'h5, 1'b0); send_beat(16'h5, 1'b0); send_beat(16'h5, 1'b0); send_beat(16'h5, 1'b0);
    chk("clear_sum_valid", {31'd0, ifa.out_valid}, 32'd1);
    chk("clear_sum_acc", {8'd0, ifa.out_acc}, 32'h14);

    // clear in DONE overrides the handshake and discards the total
    clear_a = 1'b1; ifa.out_ready = 1'b1;
    step();
    clear_a = 1'b0; ifa.out_ready = 1'b0;
    chk("clear_done_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("clear_done_acc", {8'd0, ifa.out_acc}, 32'd0);

    // ACC_W=18: 4 x 0x1FFFF overflows
    ifb.in_valid = 1'b1; ifb.in_sum = 16'hFFFF; ifb.in_cout = 1'b1;
    repeat (4) step();
    ifb.in_valid = 1'b0;
`ifdef ACC_SAT_EN
    exp_b = 18'h3FFFF;
`else
    exp_b = 18'h3FFFC;
`endif
    chk("ovf_out_valid", {31'd0, ifb.out_valid}, 32'd1);
    chk("ovf_out_acc", {14'd0, ifb.out_acc}, {14'd0, exp_b});
    chk("ovf_out_ovf", {31'd0, ifb.out_ovf}, 32'd1);
    ifb.out_ready = 1'b1;
    step();
    ifb.out_ready = 1'b0;
    chk("ovf_handoff_busy", {31'd0, busy_b}, 32'd0);

    // BLOCK_LEN=1: single beat completes the block
    ifc.in_valid = 1'b1; ifc.in_sum = 16'h00FF; ifc.in_cout = 1'b0;
    step();
    ifc.in_sum = 16'h0011;
    chk("len1_out_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("len1_out_acc", {8'd0, ifc.out_acc}, 32'hFF);
    chk("len1_in_ready", {31'd0, ifc.in_ready}, 32'd0);
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;
    chk("len1_idle", {31'd0, busy_c}, 32'd0);
    step();
    ifc.in_valid = 1'b0;
    chk("len1_second_acc", {8'd0, ifc.out_acc}, 32'h11);
    ifc.out_ready = 1'b1;
    step();
    ifc.out_ready = 1'b0;

    // asynchronous reset while in DONE
    send_beat(16'h1, 1'b0); send_beat(16'h1, 1'b0); send_beat(16'h1, 1'b0); send_beat(16'h1, 1'b0);
    chk("prerst_out_valid", {31'd0, ifa.out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, ifa.out_valid}, 32'd0);
    chk("arst_out_acc", {8'd0, ifa.out_acc}, 32'd0);
    chk("arst_busy", {31'd0, busy_a}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, ifa.in_ready}, 32'd1);
    step();

    // randomized traffic against a queue-based block model
    pending = 1'b0; m_acc = '0; m_ovf = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      ifa.in_valid  = ($urandom_range(0, 1) == 1);
      ifa.in_sum    = 16'($urandom());
      ifa.in_cout   = 1'($urandom_range(0, 1));
      ifa.out_ready = ($urandom_range(0, 2) == 0);
      clear_a       = ($urandom_range(0, 31) == 0);
      chk("rnd_in_ready", {31'd0, ifa.in_ready}, {31'd0, !pending});
      chk("rnd_out_valid", {31'd0, ifa.out_valid}, {31'd0, pending});
      if (pending) begin
        chk("rnd_out_acc", {8'd0, ifa.out_acc}, {8'd0, m_acc});
        chk("rnd_out_ovf", {31'd0, ifa.out_ovf}, {31'd0, m_ovf});
      end
      if (clear_a) begin
        q.delete();
        pending = 1'b0;
      end else if (pending) begin
        if (ifa.out_ready) pending = 1'b0;
      end else if (ifa.in_valid) begin
        q.push_back({15'd0, ifa.in_cout, ifa.in_sum});
        if (q.size() == 4) begin
          tot = 0;
          foreach (q[j]) tot += q[j];
          m_acc = 24'(tot % 64'h1000000);
          m_ovf = (tot >= 64'h1000000);
          pending = 1'b1;
          q.delete();
        end
      end
      step();
    end
    clear_a = 1'b0; ifa.in_valid = 1'b0; ifa.out_ready = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/add16_block_accumulator.md
Name: add16_block_accumulator

Overview:
- Downstream consumer of the 16-bit adder stage.
- Takes each adder result (16-bit sum plus carry-out) through a valid/ready handshake and accumulates BLOCK_LEN results into a wide accumulator.
- Presents the block total, with a sticky overflow flag, on a valid/ready output port to the next stage.
- Frees the adder from holding results; gives the datapath a multi-operand summation stage.

Parameters:
- DATA_W, 16, width of adder sum input.
- ACC_W, 24, accumulator/output width; must be >= DATA_W+1.
- BLOCK_LEN, 4, results accumulated per output block; >= 1, <= 255.

Ports:
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort/flush, highest priority after rst.
- in_valid  in  1  adder result valid.
- in_ready  out  1  block can accept a result this cycle.
- in_sum  in  DATA_W  adder sum.
- in_cout  in  1  adder carry-out.
- out_valid  out  1  block total available.
- out_ready  in  1  downstream accepts total.
- out_acc  out  ACC_W  block total.
- out_ovf  out  1  total exceeded ACC_W bits during block (sticky per block).
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_acc=0, out_ovf=0, busy=0. in_ready=1 once rst is released.
- Operand value: {in_cout, in_sum}, unsigned DATA_W+1 bits, zero-extended to ACC_W.
- Beat acceptance: a beat is accepted when in_valid && in_ready at a rising edge.
- in_ready: combinational from state only; 1 in IDLE and ACCUM, 0 in DONE. No dependence on in_valid.
- FSM IDLE:
  - acc=0, cnt=0.
  - On an accepted beat: acc<=operand, cnt<=1, ovf<=0.
  - Next state is ACCUM, or DONE if BLOCK_LEN==1.
- FSM ACCUM:
  - On an accepted beat: acc<=acc+operand (ACC_W+1-bit add), cnt<=cnt+1.
  - ovf<=ovf | carry out of bit ACC_W-1.
  - When the beat is number BLOCK_LEN, next state is DONE.
  - Cycles without in_valid hold all state.
- FSM DONE:
  - out_valid=1; out_acc and out_ovf driven from registers and held stable while out_ready=0.
  - On out_valid && out_ready: go to IDLE, acc<=0, cnt<=0.
  - No new beat is accepted in the handoff cycle, because in_ready=0 in DONE.
- Latency: out_valid rises the cycle after the edge that accepts the final beat. Minimum block period is BLOCK_LEN+1 cycles.
- Wrap: without the optional feature, acc wraps modulo 2^ACC_W.
- clear:
  - Synchronous; any state goes to IDLE, acc=0, cnt=0, ovf=0, out_valid=0.
  - A beat presented in the same cycle is dropped; in_ready still reads 1 if the state was IDLE/ACCUM.
  - clear overrides a simultaneous out_ready handshake; the total is discarded.
- rst mid-operation: immediate return to reset values regardless of clk; partial sum is lost.
- out_acc/out_ovf outside DONE: hold last delivered values (0 after reset/clear). Downstream must qualify with out_valid.

Optional Feature:
- Macro: ACC_SAT_EN.
- Defined: on overflow, acc saturates to all-ones (2^ACC_W-1) and stays there for the rest of the block; out_ovf=1 as usual.
- Undefined: modulo wrap as above; out_ovf still set.
- Ports and timing are identical in both builds.

Test Plan:
- Defaults; beats 0x0001,0x0002,0x0003,0x0004, cout=0, back-to-back -> out_valid 1 cycle after 4th accept; out_acc=0x00000A, out_ovf=0; IDLE after out_ready.
- Defaults; 4 beats sum=0xFFFF cout=1, gaps of 2 idle cycles between beats -> out_acc=0x07FFFC, out_ovf=0; gaps do not change count.
- ACC_W=18; 4 beats of 0x1FFFF:
  - ACC_SAT_EN undefined -> out_acc=0x3FFFC, out_ovf=1.
  - ACC_SAT_EN defined -> out_acc=0x3FFFF, out_ovf=1.
- Total 0x10 held with out_ready=0 for 5 cycles -> out_valid=1, in_ready=0, out_acc stable; in_valid held high is not accepted; handoff on cycle 6, then next block starts clean.
- Assert clear after 2 of 4 beats, then send 0x5,0x5,0x5,0x5 -> out_acc=0x000014; the first partial is discarded.
- Pulse rst asynchronously (mid-cycle) while in DONE -> out_valid drops immediately, out_acc=0, busy=0, in_ready=1 after release; BLOCK_LEN=1 build: single beat 0x00FF -> out_acc=0x0000FF next cycle.
